// File: rtl/piece_lock_controller_if.sv
// rtl/piece_lock_controller_if.sv - shared piece/board types and the lock controller port bundle
package tetris_pkg;
  localparam int GRID_SIZE = 4;

  // piece[px][py]: py is the row inside the grid, increasing downward
  typedef struct packed {
    logic [3:0]                           x;
    logic [4:0]                           y;
    logic [GRID_SIZE-1:0][GRID_SIZE-1:0]  piece;
  } active_piece_grid_t;
endpackage

package game_state_pkg;
  localparam int BOARD_WIDTH  = 10;
  localparam int BOARD_HEIGHT = 20;

  typedef struct packed {
    logic [BOARD_WIDTH-1:0][BOARD_HEIGHT-1:0] screen;
  } game_state_t;
endpackage

interface piece_lock_controller_if;
  logic                            gravity_tick;
  logic                            active_piece_toutching;
  logic                            no_piece;
  tetris_pkg::active_piece_grid_t  active_piece_grid;
  game_state_pkg::game_state_t     GAME_fixed_state;
  logic                            busy;
  logic                            piece_locked;
  logic                            spawn_req;
  logic                            lines_valid;
  logic [2:0]                      lines_cleared;
  logic                            game_over;

  modport master (
    output gravity_tick, active_piece_toutching, no_piece, active_piece_grid,
    input  GAME_fixed_state, busy, piece_locked, spawn_req, lines_valid,
           lines_cleared, game_over
  );

  modport slave (
    input  gravity_tick, active_piece_toutching, no_piece, active_piece_grid,
    output GAME_fixed_state, busy, piece_locked, spawn_req, lines_valid,
           lines_cleared, game_over
  );
endinterface

// File: rtl/piece_lock_controller.sv
// rtl/piece_lock_controller.sv - lock delay, piece merge and one-row-per-cycle line compaction
module piece_lock_controller #(
  parameter int LOCK_TICKS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  piece_lock_controller_if.slave  pl
);
  import tetris_pkg::*;
  import game_state_pkg::*;

  localparam int CNT_W = (LOCK_TICKS < 2) ? 1 : $clog2(LOCK_TICKS + 1);

  typedef enum logic [1:0] {S_IDLE, S_MERGE, S_CLEAR, S_SPAWN} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    lock_cnt_q, lock_cnt_d;
  logic [4:0]          row_q, row_d;
  logic [2:0]          count_q, count_d;
  active_piece_grid_t  grid_q, grid_d;
  game_state_t         board_q, board_d;
  logic                game_over_q, game_over_d;
  logic                busy_q, busy_d;
  logic                piece_locked_q, piece_locked_d;
  logic                spawn_req_q, spawn_req_d;
  logic                lines_valid_q, lines_valid_d;
  logic [2:0]          lines_cleared_q, lines_cleared_d;

  game_state_t         merged;
  logic                merge_err;
  logic [4:0]          tx;
  logic [5:0]          ty;
  game_state_t         shifted;
  logic                row_full;

  // Targets are one bit wider than the board index so off-board cells never wrap
  always_comb begin
    merged    = board_q;
    merge_err = 1'b0;
    tx        = '0;
    ty        = '0;
    for (int px = 0; px < GRID_SIZE; px++) begin
      for (int py = 0; py < GRID_SIZE; py++) begin
        if (grid_q.piece[px][py]) begin
          tx = {1'b0, grid_q.x} + 5'(px);
          ty = {1'b0, grid_q.y} + 6'(py);
          if (tx >= 5'(BOARD_WIDTH) || ty >= 6'(BOARD_HEIGHT)) begin
            merge_err = 1'b1;
          end else begin
            if (board_q.screen[tx[3:0]][ty[4:0]] || ty == 6'd0) merge_err = 1'b1;
            merged.screen[tx[3:0]][ty[4:0]] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    row_full = 1'b1;
    for (int c = 0; c < BOARD_WIDTH; c++) row_full = row_full & board_q.screen[c][row_q];
    shifted = board_q;
    for (int k = 1; k < BOARD_HEIGHT; k++) begin
      if (5'(k) <= row_q) begin
        for (int c = 0; c < BOARD_WIDTH; c++) shifted.screen[c][k] = board_q.screen[c][k-1];
      end
    end
    for (int c = 0; c < BOARD_WIDTH; c++) shifted.screen[c][0] = 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    lock_cnt_d  = lock_cnt_q;
    row_d       = row_q;
    count_d     = count_q;
    grid_d      = grid_q;
    board_d     = board_q;
    game_over_d = game_over_q;
    case (state_q)
      S_IDLE: begin
        if (game_over_q || !pl.active_piece_toutching || pl.no_piece) begin
          lock_cnt_d = '0;
        end else if (pl.gravity_tick) begin
          if (lock_cnt_q == CNT_W'(LOCK_TICKS - 1)) begin
            lock_cnt_d = '0;
            grid_d     = pl.active_piece_grid;
            state_d    = S_MERGE;
          end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end
        end
      end
      S_MERGE: begin
        board_d     = merged;
        game_over_d = game_over_q | merge_err;
        row_d       = 5'(BOARD_HEIGHT - 1);
        count_d     = 3'd0;
        state_d     = S_CLEAR;
      end
      S_CLEAR: begin
        // A cleared row pulls the rows above down, so the same index is re-checked
        if (row_full) begin
          board_d = shifted;
          count_d = count_q + 3'd1;
          if (count_q == 3'd3) state_d = S_SPAWN;
        end else if (row_q == 5'd0) begin
          state_d = S_SPAWN;
        end else begin
          row_d = row_q - 5'd1;
        end
      end
      S_SPAWN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    piece_locked_d  = (state_d == S_MERGE);
    spawn_req_d     = (state_d == S_SPAWN);
    lines_valid_d   = (state_d == S_SPAWN);
    lines_cleared_d = (state_d == S_SPAWN) ? count_d : lines_cleared_q;
    busy_d          = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      lock_cnt_q      <= '0;
      row_q           <= 5'(BOARD_HEIGHT - 1);
      count_q         <= 3'd0;
      grid_q          <= '0;
      board_q         <= '0;
      game_over_q     <= 1'b0;
      busy_q          <= 1'b0;
      piece_locked_q  <= 1'b0;
      spawn_req_q     <= 1'b0;
      lines_valid_q   <= 1'b0;
      lines_cleared_q <= 3'd0;
    end else begin
      state_q         <= state_d;
      lock_cnt_q      <= lock_cnt_d;
      row_q           <= row_d;
      count_q         <= count_d;
      grid_q          <= grid_d;
      board_q         <= board_d;
      game_over_q     <= game_over_d;
      busy_q          <= busy_d;
      piece_locked_q  <= piece_locked_d;
      spawn_req_q     <= spawn_req_d;
      lines_valid_q   <= lines_valid_d;
      lines_cleared_q <= lines_cleared_d;
    end
  end

  assign pl.GAME_fixed_state = board_q;
  assign pl.busy             = busy_q;
  assign pl.piece_locked     = piece_locked_q;
  assign pl.spawn_req        = spawn_req_q;
  assign pl.lines_valid      = lines_valid_q;
  assign pl.lines_cleared    = lines_cleared_q;
  assign pl.game_over        = game_over_q;
endmodule

// File: tb/tb_piece_lock_controller.sv
// tb/tb_piece_lock_controller.sv - directed vector bench for piece_lock_controller
module tb_piece_lock_controller;
  import tetris_pkg::*;
  import game_state_pkg::*;

  localparam logic [15:0] P_O    = 16'h0033;
  localparam logic [15:0] P_H4   = 16'h1111;
  localparam logic [15:0] P_H2   = 16'h0011;
  localparam logic [15:0] P_VI   = 16'h000F;
  localparam logic [15:0] P_VIB  = 16'h008F;
  localparam logic [15:0] P_FULL = 16'hFFFF;
  localparam logic [15:0] P_DIAG = 16'h8421;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  piece_lock_controller_if pif();
  piece_lock_controller #(.LOCK_TICKS(2)) dut (.clk(clk), .reset(reset), .pl(pif));

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic tick;
    logic tch;
    logic np;
    logic exp_lk;
    logic exp_busy;
  } vec_t;
  vec_t vt[13];

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  function automatic active_piece_grid_t mk(input int x, input int y, input logic [15:0] bits);
    active_piece_grid_t g;
    g.x     = 4'(x);
    g.y     = 5'(y);
    g.piece = bits;
    return g;
  endfunction

  task automatic do_ticks(input active_piece_grid_t g, output logic lk);
    pif.active_piece_grid      = g;
    pif.active_piece_toutching = 1'b1;
    pif.no_piece               = 1'b0;
    pif.gravity_tick           = 1'b1;
    cyc();
    pif.gravity_tick = 1'b0;
    cyc();
    pif.gravity_tick = 1'b1;
    cyc();
    lk = pif.piece_locked;
    pif.gravity_tick           = 1'b0;
    pif.active_piece_toutching = 1'b0;
  endtask

  task automatic lock(input active_piece_grid_t g, output logic lk, output int spawn_at,
                      output logic [2:0] lines, output logic lv);
    do_ticks(g, lk);
    spawn_at = -1;
    lines    = 3'd7;
    lv       = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (pif.spawn_req) begin
        spawn_at = i;
        lines    = pif.lines_cleared;
        lv       = pif.lines_valid;
        break;
      end
    end
    cyc();
  endtask

  initial begin
    logic        lk, lv;
    int          sa, spawns;
    logic [2:0]  ln;
    game_state_t e;

    reset                      = 1'b1;
    pif.gravity_tick           = 1'b0;
    pif.active_piece_toutching = 1'b0;
    pif.no_piece               = 1'b0;
    pif.active_piece_grid      = '0;
    cyc();
    cyc();
    check("reset_board", pif.GAME_fixed_state, '0);
    check("reset_flags", {pif.busy, pif.piece_locked, pif.spawn_req, pif.lines_valid,
                          pif.lines_cleared, pif.game_over}, '0);
    reset = 1'b0;
    cyc();

    // Lock timing with an O piece at the bottom
    lock(mk(4, 18, P_O), lk, sa, ln, lv);
    e = '0;
    e.screen[4][18] = 1'b1; e.screen[5][18] = 1'b1;
    e.screen[4][19] = 1'b1; e.screen[5][19] = 1'b1;
    check("t1_locked", lk, 1'b1);
    check("t1_spawn_at", sa, 21);
    check("t1_lines", ln, 3'd0);
    check("t1_lines_valid", lv, 1'b1);
    check("t1_board", pif.GAME_fixed_state, e);
    check("t1_idle", pif.busy, 1'b0);

    // Lock counter qualification, cycle by cycle
    vt[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vt[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    pif.active_piece_grid = mk(0, 10, P_O);
    for (int i = 0; i < 13; i++) begin
      pif.gravity_tick           = vt[i].tick;
      pif.active_piece_toutching = vt[i].tch;
      pif.no_piece               = vt[i].np;
      cyc();
      check($sformatf("vec%0d_lk_busy", i), {pif.piece_locked, pif.busy},
            {vt[i].exp_lk, vt[i].exp_busy});
    end
    pif.gravity_tick = 1'b0;
    pif.active_piece_toutching = 1'b0;
    pif.no_piece = 1'b0;
    spawns = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (pif.spawn_req) spawns++;
    end
    check("vec_spawn_count", spawns, 1);

    // Single line completed by a vertical I plus a block in column 7
    do_reset();
    lock(mk(0, 19, P_H4), lk, sa, ln, lv);
    lock(mk(4, 19, P_H2), lk, sa, ln, lv);
    lock(mk(8, 19, P_H2), lk, sa, ln, lv);
    check("t3_prefill_lines", ln, 3'd0);
    lock(mk(6, 16, P_VIB), lk, sa, ln, lv);
    e = '0;
    e.screen[6][17] = 1'b1; e.screen[6][18] = 1'b1; e.screen[6][19] = 1'b1;
    check("t3_lines", ln, 3'd1);
    check("t3_spawn_at", sa, 22);
    check("t3_board", pif.GAME_fixed_state, e);
    check("t3_lines_hold", {pif.lines_valid, pif.lines_cleared}, {1'b0, 3'd1});

    // Tetris: four rows cleared, SPAWN on the fourth clear
    do_reset();
    lock(mk(0, 16, P_FULL), lk, sa, ln, lv);
    lock(mk(4, 16, P_FULL), lk, sa, ln, lv);
    lock(mk(8, 16, P_VI), lk, sa, ln, lv);
    lock(mk(0, 12, P_DIAG), lk, sa, ln, lv);
    lock(mk(9, 16, P_VI), lk, sa, ln, lv);
    e = '0;
    for (int p = 0; p < 4; p++) e.screen[p][16+p] = 1'b1;
    check("t4_lines", ln, 3'd4);
    check("t4_spawn_at", sa, 5);
    check("t4_board", pif.GAME_fixed_state, e);
    check("t4_game_over", pif.game_over, 1'b0);

    // Reset during the fifth CLEAR cycle
    do_ticks(mk(4, 10, P_O), lk);
    check("t6_locked", lk, 1'b1);
    for (int i = 0; i < 5; i++) cyc();
    check("t6_busy_before", pif.busy, 1'b1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("t6_board", pif.GAME_fixed_state, '0);
    check("t6_flags", {pif.busy, pif.spawn_req, pif.lines_valid}, 3'b000);
    spawns = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (pif.spawn_req || pif.lines_valid) spawns++;
    end
    check("t6_no_spawn", spawns, 0);

    // Game over from a cell in row 0, then ticks are ignored
    lock(mk(0, 0, P_O), lk, sa, ln, lv);
    e = '0;
    e.screen[0][0] = 1'b1; e.screen[1][0] = 1'b1;
    e.screen[0][1] = 1'b1; e.screen[1][1] = 1'b1;
    check("t5a_game_over", pif.game_over, 1'b1);
    check("t5a_board", pif.GAME_fixed_state, e);
    do_ticks(mk(4, 10, P_O), lk);
    check("t5a_no_lock", lk, 1'b0);
    spawns = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (pif.busy || pif.piece_locked) spawns++;
    end
    check("t5a_stay_idle", spawns, 0);
    check("t5a_sticky", pif.game_over, 1'b1);
    check("t5a_board_hold", pif.GAME_fixed_state, e);

    // Game over from overlap
    do_reset();
    lock(mk(2, 10, P_O), lk, sa, ln, lv);
    check("t5b_first_ok", pif.game_over, 1'b0);
    lock(mk(2, 9, P_O), lk, sa, ln, lv);
    check("t5b_overlap", pif.game_over, 1'b1);

    // Game over from off-board cells; they are dropped, not wrapped
    do_reset();
    lock(mk(9, 19, P_O), lk, sa, ln, lv);
    e = '0;
    e.screen[9][19] = 1'b1;
    check("t5c_game_over", pif.game_over, 1'b1);
    check("t5c_board", pif.GAME_fixed_state, e);
    check("t5c_spawn_at", sa, 21);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
